// File: rtl/vertex_scaler_pipe.sv
// vertex_scaler_pipe: two-stage stallable screen-space scaler.
//   Each accepted vertex is turned into scaled = sat((raw * scale) >>> SHIFT + offset)
//   for X and Y. Z passes through unchanged.
//   Every vertex is tagged with its index within a primitive of NUM_VTX vertices.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          input handshake
//   in_x/in_y/in_z             signed raw coordinates
//   scale_x/scale_y            unsigned scale factors, sampled with the vertex
//   off_x/off_y                signed post-shift offsets, sampled with the vertex
//   out_valid/out_ready        output handshake
//   out_x/out_y/out_z          scaled X/Y and pass-through Z
//   out_sat                    bit0 = X clamped, bit1 = Y clamped
//   vtx_idx/vtx_last           index of the vertex in its primitive, last-vertex flag

// Per-coordinate datapath: S1 registers the product, S2 shifts, offsets and clamps.
module vertex_scaler_lane #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int SHIFT  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld1,
  input  logic              ld2,
  input  logic [DATA_W-1:0] raw,
  input  logic [COEF_W-1:0] scl,
  input  logic [DATA_W-1:0] off,
  output logic [DATA_W-1:0] res,
  output logic              sat
);
  localparam int PW = DATA_W + COEF_W + 1;
  // Clamp bounds at the (PW+1)-bit sum width.
  localparam logic signed [PW:0] MAXV = {{(PW-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW:0] MINV = ~MAXV;

  logic signed [PW-1:0]     raw_e, scl_e, prod, px, shf;
  logic signed [PW:0]       sum;
  logic        [DATA_W-1:0] off1;

  // Raw is sign-extended, scale zero-extended, so the product is exact in PW bits.
  assign raw_e = {{(COEF_W+1){raw[DATA_W-1]}}, raw};
  assign scl_e = {{(DATA_W+1){1'b0}}, scl};
  assign prod  = raw_e * scl_e;
  assign shf   = px >>> SHIFT;
  assign sum   = {shf[PW-1], shf} + {{(PW+1-DATA_W){off1[DATA_W-1]}}, off1};

  always_ff @(posedge clk) begin
    if (rst) begin
      px   <= '0;
      off1 <= '0;
      res  <= '0;
      sat  <= 1'b0;
    end else begin
      if (ld1) begin
        px   <= prod;
        off1 <= off;
      end
      if (ld2) begin
        if (sum > MAXV) begin
          res <= MAXV[DATA_W-1:0];
          sat <= 1'b1;
        end else if (sum < MINV) begin
          res <= MINV[DATA_W-1:0];
          sat <= 1'b1;
        end else begin
          res <= sum[DATA_W-1:0];
          sat <= 1'b0;
        end
      end
    end
  end
endmodule

module vertex_scaler_pipe #(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int SHIFT   = 5,
  parameter int NUM_VTX = 4,
  parameter int IDX_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_z,
  input  logic [COEF_W-1:0] scale_x,
  input  logic [COEF_W-1:0] scale_y,
  input  logic [DATA_W-1:0] off_x,
  input  logic [DATA_W-1:0] off_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic [DATA_W-1:0] out_z,
  output logic [1:0]        out_sat,
  output logic [IDX_W-1:0]  vtx_idx,
  output logic              vtx_last
);
  localparam int LANES  = 2;
  localparam int STAGES = 2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VTX - 1);

  logic [STAGES:1]                 vld_pipe;  // [1] = S1 valid, [2] = S2 valid
  logic                            accept, s2_load, s1_adv;
  logic [LANES-1:0][DATA_W-1:0]    raw, off, res;
  logic [LANES-1:0][COEF_W-1:0]    scl;
  logic [LANES-1:0]                sat;
  logic [IDX_W-1:0]                idx_q, idx1;
  logic [DATA_W-1:0]               z1;

  // Ready depends only on out_ready and internal valids, never on in_valid.
  assign s2_load   = !vld_pipe[2] || out_ready;
  assign s1_adv    = vld_pipe[1] && s2_load;
  assign in_ready  = !vld_pipe[1] || s2_load;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_pipe[2];

  assign raw     = {in_y, in_x};
  assign scl     = {scale_y, scale_x};
  assign off     = {off_y, off_x};
  assign out_x   = res[0];
  assign out_y   = res[1];
  assign out_sat = sat;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vertex_scaler_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W), .SHIFT(SHIFT)) u_lane (
      .clk (clk),
      .rst (rst),
      .ld1 (accept),
      .ld2 (s1_adv),
      .raw (raw[l]),
      .scl (scl[l]),
      .off (off[l]),
      .res (res[l]),
      .sat (sat[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      idx_q    <= '0;
      idx1     <= '0;
      z1       <= '0;
      out_z    <= '0;
      vtx_idx  <= '0;
      vtx_last <= 1'b0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s2_load)  vld_pipe[2] <= vld_pipe[1];
      if (accept) begin
        z1    <= in_z;
        idx1  <= idx_q;
        idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
      end
      if (s1_adv) begin
        out_z    <= z1;
        vtx_idx  <= idx1;
        vtx_last <= (idx1 == LAST);
      end
    end
  end
endmodule

// File: tb/tb_vertex_scaler_pipe.sv
// Bench for vertex_scaler_pipe: two instances (NUM_VTX=4 and NUM_VTX=3) share stimulus.
// A queue-based model predicts every delivery, out_valid and in_ready each cycle;
// hand-computed literals pin the model on the directed vectors.
module tb_vertex_scaler_pipe;
  localparam int SH = 5;

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic signed [15:0] in_x = 0, in_y = 0, in_z = 0, off_x = 0, off_y = 0;
  logic [15:0] scale_x = 0, scale_y = 0;

  logic in_ready, out_valid, vtx_last;
  logic signed [15:0] out_x, out_y, out_z;
  logic [1:0] out_sat, vtx_idx;
  logic in_ready3, out_valid3, vtx_last3;
  logic signed [15:0] out_x3, out_y3, out_z3;
  logic [1:0] out_sat3, vtx_idx3;

  always #5 clk = ~clk;

  vertex_scaler_pipe #(.NUM_VTX(4), .IDX_W(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .scale_x(scale_x), .scale_y(scale_y),
    .off_x(off_x), .off_y(off_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_sat(out_sat),
    .vtx_idx(vtx_idx), .vtx_last(vtx_last));

  vertex_scaler_pipe #(.NUM_VTX(3), .IDX_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .scale_x(scale_x), .scale_y(scale_y),
    .off_x(off_x), .off_y(off_y), .out_valid(out_valid3), .out_ready(out_ready),
    .out_x(out_x3), .out_y(out_y3), .out_z(out_z3), .out_sat(out_sat3),
    .vtx_idx(vtx_idx3), .vtx_last(vtx_last3));

  int tests = 0, fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    longint x, y, z;
    int sat, i4, l4, i3, l3, acc;
  } exp_t;

  exp_t q[$];
  longint lx[$], ly[$];
  int lsat[$], li4[$], ll4[$], li3[$], ll3[$];
  int cyc = 0, c4 = 0, c3 = 0;
  bit have_hold = 0, saw_full = 0;
  longint hx, hy, hz;
  int hs, hi;

  function automatic void scale1(input longint r, input longint s, input longint o,
                                 output longint v, output bit st);
    longint t;
    t = ((r * s) >>> SH) + o;
    st = 1;
    if (t > 32767) v = 32767;
    else if (t < -32768) v = -32768;
    else begin v = t; st = 0; end
  endfunction

  // Compare process: at each falling edge decide what the next rising edge does.
  always @(negedge clk) begin
    exp_t e;
    bit sx, sy;
    cyc++;
    if (rst) begin
      q.delete(); c4 = 0; c3 = 0; have_hold = 0;
    end else begin
      if (have_hold) begin
        chk("hold_x", out_x, hx); chk("hold_y", out_y, hy); chk("hold_z", out_z, hz);
        chk("hold_sat", out_sat, hs); chk("hold_idx", vtx_idx, hi);
      end
      chk("out_valid", out_valid, (q.size() > 0 && cyc - q[0].acc >= 2));
      chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      chk("out_valid3", out_valid3, out_valid);
      chk("in_ready3", in_ready3, in_ready);
      if (!in_ready) saw_full = 1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("stale_delivery", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_x", out_x, e.x); chk("out_y", out_y, e.y); chk("out_z", out_z, e.z);
          chk("out_sat", out_sat, e.sat);
          chk("vtx_idx", vtx_idx, e.i4); chk("vtx_last", vtx_last, e.l4);
          chk("out_x3", out_x3, e.x); chk("out_y3", out_y3, e.y);
          chk("vtx_idx3", vtx_idx3, e.i3); chk("vtx_last3", vtx_last3, e.l3);
          lx.push_back(out_x); ly.push_back(out_y); lsat.push_back(out_sat);
          li4.push_back(vtx_idx); ll4.push_back(vtx_last);
          li3.push_back(vtx_idx3); ll3.push_back(vtx_last3);
        end
      end
      have_hold = out_valid && !out_ready;
      hx = out_x; hy = out_y; hz = out_z; hs = out_sat; hi = vtx_idx;
      if (in_valid && in_ready) begin
        scale1(in_x, scale_x, off_x, e.x, sx);
        scale1(in_y, scale_y, off_y, e.y, sy);
        e.z = in_z; e.sat = {sy, sx};
        e.i4 = c4; e.l4 = (c4 == 3); e.i3 = c3; e.l3 = (c3 == 2); e.acc = cyc;
        c4 = (c4 + 1) % 4; c3 = (c3 + 1) % 3;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input int x, input int y, input int z, input int sx, input int sy,
                       input int ox, input int oy);
    bit ok = 0;
    in_valid = 1; in_x = 16'(x); in_y = 16'(y); in_z = 16'(z);
    scale_x = 16'(sx); scale_y = 16'(sy); off_x = 16'(ox); off_y = 16'(oy);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    idle(3);
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0); chk("rst_in_ready", in_ready, 1);
    chk("rst_out_x", out_x, 0); chk("rst_out_sat", out_sat, 0);
    chk("rst_vtx_idx", vtx_idx, 0); chk("rst_vtx_last", vtx_last, 0);
    @(posedge clk); #1;

    // Basic vectors
    drive(1, 1, 7, 16'h2800, 16'h1E00, 0, 0);
    @(negedge clk); chk("lat_cycle1", out_valid, 0);
    @(negedge clk); chk("lat_cycle2", out_valid, 1);
    @(posedge clk); #1;
    drive(-1, -2, 0, 16'h2800, 16'h1E00, 320, 240);
    drive(200, 1, 0, 16'h2800, 16'h1E00, 0, 0);
    drive(-200, 1, 0, 16'h2800, 16'h1E00, 0, 0);
    idle(5);
    chk("n_basic", lx.size(), 4);
    chk("b0_x", lx[0], 320); chk("b0_y", ly[0], 240); chk("b0_sat", lsat[0], 0);
    chk("b1_x", lx[1], 0); chk("b1_y", ly[1], -240); chk("b1_sat", lsat[1], 0);
    chk("b2_x", lx[2], 32767); chk("b2_sat", lsat[2], 1);
    chk("b3_x", lx[3], -32768); chk("b3_sat", lsat[3], 1);

    // Reset pulse so the burst starts at index 0
    rst = 1; idle(1); rst = 0; idle(1);

    // 8-vertex burst with out_ready low for cycles 3..5
    saw_full = 0;
    fork
      for (int k = 0; k < 8; k++) drive(10 * k + 3, -k, k, 16'h0100, 16'h0100, k, 0);
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 3 && c <= 5);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    idle(6);
    chk("burst_full_seen", saw_full, 1);
    chk("n_burst", lx.size(), 12);
    for (int k = 0; k < 8; k++) begin
      chk("burst_x", lx[4 + k], 81 * k + 24);
      chk("burst_y", ly[4 + k], -8 * k);
      chk("burst_idx4", li4[4 + k], k % 4);
      chk("burst_last4", ll4[4 + k], (k % 4) == 3);
      chk("burst_idx3", li3[4 + k], k % 3);
      chk("burst_last3", ll3[4 + k], (k % 3) == 2);
    end

    // Reset with two vertices in flight
    out_ready = 0;
    drive(5, 5, 5, 16'h0100, 16'h0100, 0, 0);
    drive(6, 6, 6, 16'h0100, 16'h0100, 0, 0);
    rst = 1; idle(1); rst = 0; out_ready = 1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0); chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    // scale 0 yields the offset; -1 >>> 5 rounds to -1
    drive(123, -1, 9, 0, 1, -5, 0);
    idle(6);
    chk("n_final", lx.size(), 13);
    chk("post_x", lx[12], -5); chk("post_y", ly[12], -1);
    chk("post_idx4", li4[12], 0); chk("post_idx3", li3[12], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule

// File: doc/vertex_scaler_pipe.md
Name: vertex_scaler_pipe

Overview:
- Pipelined, stallable successor to the combinational screen-space scaler in the render path.
- Takes one raw vertex (X, Y, Z) per accepted beat and computes the scaled result: scaled = sat((raw * scale) >>> SHIFT + offset).
- Scale factors and offsets are runtime inputs; Z passes through. Output width is parametrised and saturating.
- Tags each vertex with its index within a primitive of NUM_VTX vertices. Sits between the vertex fetch stage and the rasteriser setup stage.

Parameters:
- DATA_W, 16, signed width of raw and scaled coordinates.
- COEF_W, 16, unsigned width of the scale factors.
- SHIFT, 5, arithmetic right shift applied to each product.
- NUM_VTX, 4, vertices per primitive; sets the index wrap point. Minimum 1.
- IDX_W, 2, width of vtx_idx; must satisfy 2^IDX_W >= NUM_VTX.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input vertex valid.
- in_ready  out  1  input can be accepted this cycle.
- in_x, in_y, in_z  in  DATA_W  signed raw coordinates.
- scale_x, scale_y  in  COEF_W  unsigned scale factors; sampled with the vertex.
- off_x, off_y  in  DATA_W  signed post-shift offsets; sampled with the vertex.
- out_valid  out  1  output vertex valid.
- out_ready  in  1  downstream accepts the output.
- out_x, out_y, out_z  out  DATA_W  scaled X and Y; passed-through Z.
- out_sat  out  2  bit0: X saturated; bit1: Y saturated.
- vtx_idx  out  IDX_W  index of this vertex within its primitive.
- vtx_last  out  1  high when vtx_idx == NUM_VTX-1.

Behaviour:
- Reset: every output and all stage valid bits go to 0, and the index counter goes to 0. in_ready is 1 from the first cycle after reset.
- A beat is accepted when in_valid && in_ready. A beat is delivered when out_valid && out_ready.

Stage 1 (S1):
- On accept, register the products px = in_x * scale_x and py = in_y * scale_y.
- Scales are zero-extended, so each product is a signed (DATA_W+COEF_W+1)-bit value.
- Also register in_z, off_x, off_y and the current index.

Stage 2 (S2):
- sx = (px >>> SHIFT) + off_x, computed at full width plus 1 bit; sy likewise.
- If sx > 2^(DATA_W-1)-1, clamp to max and set sat bit0. If sx < -2^(DATA_W-1), clamp to min and set sat bit0. Y is handled the same way with bit1.
- S2 registers drive the out_* ports directly. No combinational path runs from in_* to out_*.

Latency and throughput:
- 2 cycles from accept to out_valid when not stalled. Sustained throughput is 1 vertex per cycle.

Flow control:
- S2 loads when it is empty or being delivered this cycle. S1 advances when S2 loads.
- in_ready = !s1_valid || s1_advance. This is a combinational function of out_ready and the internal valids only; it never depends on in_valid.
- While stalled (out_valid && !out_ready), all out_* values hold stable.
- Full pipeline plus stall means in_ready = 0. At most 2 vertices are in flight, and no beat is dropped or duplicated.
- Simultaneous deliver and accept in the same cycle is allowed. Order is strictly preserved.

Index counter:
- Increments on each accept. Wraps from NUM_VTX-1 to 0.
- The index is captured with the vertex, so vtx_idx and vtx_last always match the delivered vertex.
- NUM_VTX = 1 means vtx_idx is always 0 and vtx_last is always 1.

Reset mid-operation:
- Flushes both stages: in-flight vertices are discarded and not delivered.
- Index returns to 0. out_valid is 0 on the next cycle.

Arithmetic and boundaries:
- Shift is arithmetic (rounds toward -inf). scale = 0 yields off.
- Z is never modified or saturated.

Test Plan:
- Defaults, scale_x=16'h2800, scale_y=16'h1E00, off=0, in (1,1,7) -> out (320,240,7), sat=00, out_valid exactly 2 cycles after accept.
- in_x=-1, in_y=-2, same scales, off_x=320, off_y=240 -> out_x=0, out_y=-240, sat=00.
- in_x=200, scale_x=16'h2800 (64000 before clamp) -> out_x=32767, sat bit0=1. in_x=-200 -> out_x=-32768, sat bit0=1.
- 8 back-to-back vertices with out_ready low for cycles 3-5 -> in_ready low while both stages are full, all 8 delivered in order, outputs stable during stall.
- NUM_VTX=4, 8 vertices -> vtx_idx sequence 0,1,2,3,0,1,2,3 with vtx_last on the 4th and 8th. Same for NUM_VTX=3 wrap (0,1,2,0,...).
- Assert rst with 2 vertices in flight -> next cycle out_valid=0, in_ready=1, no stale delivery. The first new vertex gets vtx_idx=0.
